// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 op encodings, FSM state encodings and small op-decode helpers.
// Pure declarations, no logic state.
package muldiv_pkg;

    // funct3 encodings of the M-extension ops
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed for these ops (MUL low half is sign-agnostic,
    // treating it as signed x signed keeps the sign-fix path uniform)
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for these ops
    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negator: dout = neg ? -din : din.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module muldiv_unit_cond_neg
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    localparam logic [W-1:0] ONE = W'(1);

    assign dout = neg ? (~din + ONE) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide.
// Latency: fixed N+2 cycles from accepted start to the done pulse, every op.
// Backpressure: stall holds the datapath while busy; start ignored unless IDLE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int             CW       = $clog2(N) + 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(N);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [N-1:0]   INT_MIN  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]   ONE_N    = N'(1);

    // FSM and latched-operation state
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    op_q,    op_d;
    logic          sa_q,    sa_d;
    logic          sb_q,    sb_d;
    logic [N-1:0]  a_q,     a_d;
    logic [N-1:0]  result_q, result_d;

    // Shared datapath: acc is the product high half / partial remainder,
    // mq is the multiplier / dividend-then-quotient, dvs the multiplicand / divisor.
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mq_q,  mq_d;
    logic [N-1:0]  dvs_q, dvs_d;

    // Operand sign decode and magnitudes at accept
    logic          sa_in, sb_in;
    logic [N-1:0]  mag_a, mag_b;

    assign sa_in = a[N-1] & a_is_signed(op);
    assign sb_in = b[N-1] & b_is_signed(op);

    muldiv_unit_cond_neg #(.W(N)) u_mag_a (.din(a), .neg(sa_in), .dout(mag_a));
    muldiv_unit_cond_neg #(.W(N)) u_mag_b (.din(b), .neg(sb_in), .dout(mag_b));

    // Sign fix of the finished magnitudes, consumed in FIX
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;

    muldiv_unit_cond_neg #(.W(2*N)) u_prod_fix (
        .din ({acc_q, mq_q}),
        .neg (sa_q ^ sb_q),
        .dout(prod_fix)
    );
    muldiv_unit_cond_neg #(.W(N)) u_quo_fix (.din(mq_q),  .neg(sa_q ^ sb_q), .dout(quo_fix));
    muldiv_unit_cond_neg #(.W(N)) u_rem_fix (.din(acc_q), .neg(sa_q),        .dout(rem_fix));

    // One multiply step: conditionally add multiplicand, then shift {acc,mq} right
    logic [N:0]   mul_sum;
    logic [N-1:0] mul_acc_nx, mul_mq_nx;

    // One restoring-divide step: shift in next dividend bit, trial-subtract divisor
    logic [N:0]   div_shift, div_trial;
    logic         div_ge;
    logic [N-1:0] div_acc_nx, div_mq_nx;

    // Per-iteration arithmetic for both paths; the FSM picks one by op
    always_comb begin
        mul_sum    = {1'b0, acc_q} + {1'b0, (mq_q[0] ? dvs_q : {N{1'b0}})};
        mul_acc_nx = mul_sum[N:1];
        mul_mq_nx  = {mul_sum[0], mq_q[N-1:1]};

        div_shift  = {acc_q, mq_q[N-1]};
        div_trial  = div_shift - {1'b0, dvs_q};
        // With acc < divisor the trial's top bit is set exactly when it borrowed
        div_ge     = ~div_trial[N];
        div_acc_nx = div_ge ? div_trial[N-1:0] : div_shift[N-1:0];
        div_mq_nx  = {mq_q[N-2:0], div_ge};
    end

    // Special cases resolved in FIX. Division by zero leaves the iteration
    // result meaningless, so it is overridden; signed overflow would come out
    // right from the magnitude path but is forced explicitly for clarity.
    logic div_zero, div_ovf;

    assign div_zero = (dvs_q == {N{1'b0}});
    assign div_ovf  = sa_q & sb_q & (a_q == INT_MIN) & (dvs_q == ONE_N);

    // Next-state, iteration and result selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        dvs_d    = dvs_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    a_d     = a;
                    acc_d   = {N{1'b0}};
                    mq_d    = mag_a;
                    dvs_d   = mag_b;
                    cnt_d   = CNT_LOAD;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (is_div(op_q)) begin
                    acc_d = div_acc_nx;
                    mq_d  = div_mq_nx;
                end else begin
                    acc_d = mul_acc_nx;
                    mq_d  = mul_mq_nx;
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                case (op_q)
                    OP_MUL:                      result_d = prod_fix[N-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*N-1:N];
                    OP_DIV, OP_DIVU: begin
                        if (div_zero)     result_d = {N{1'b1}};
                        else if (div_ovf) result_d = a_q;
                        else              result_d = quo_fix;
                    end
                    default: begin
                        if (div_zero)     result_d = a_q;
                        else if (div_ovf) result_d = {N{1'b0}};
                        else              result_d = rem_fix;
                    end
                endcase
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 3'b000;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= {N{1'b0}};
            acc_q    <= {N{1'b0}};
            mq_q     <= {N{1'b0}};
            dvs_q    <= {N{1'b0}};
            result_q <= {N{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    assign stall  = ((state_q == S_IDLE) & start) | (state_q == S_CALC) | (state_q == S_FIX);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, monitor
// pops on every done pulse and checks value and latency. Directed RV32M cases,
// mid-op reset, latched-operand hold, back-to-back issue, then random ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int N   = 32;
    localparam int LAT = N + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        stall, busy, done;
    logic [31:0] result;

    muldiv_unit #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];
    logic [2:0]  opq_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics using 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int              sa, sb;
        longint          p;
        longint unsigned pu;
        logic [31:0]     r;
        bit              ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = longint'(sa) * longint'(sb); r = p[31:0]; end
            OP_MULH:   begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            OP_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; end
            OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
            OP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding op
    always @(negedge clk) begin
        logic [31:0] e;
        int          c;
        logic [2:0]  o;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending op", cyc);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                o = opq_q.pop_front();
                chk($sformatf("result op=%0d", o), result, e);
                chk($sformatf("latency op=%0d", o), 32'(cyc - c), 32'(LAT));
            end
        end
    end

    // Issue one op with start held through the stall, as the datapath would;
    // optionally scramble op/a/b mid-CALC to prove the latched copies are used.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit perturb);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk1("idle_before_issue", busy, 1'b0);
        start = 1'b1;
        op_i  = o;
        a_i   = a;
        b_i   = b;
        exp_q.push_back(ref_model(o, a, b));
        cyc_q.push_back(cyc);
        opq_q.push_back(o);
        #1;
        chk1("stall_c0", stall, 1'b1);
        chk1("busy_c0", busy, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("stall_c%0d", k), stall, (k < LAT));
            chk1($sformatf("busy_c%0d", k), busy, 1'b1);
            if (perturb && k == 5) begin
                a_i  = $urandom;
                b_i  = $urandom;
                op_i = 3'($urandom);
            end
        end
        start = 1'b0;
    endtask

    logic [2:0]  d_op[12];
    logic [31:0] d_a[12];
    logic [31:0] d_b[12];

    initial begin
        d_op[0]  = OP_MUL;    d_a[0]  = 32'd7;          d_b[0]  = 32'hFFFF_FFFD;
        d_op[1]  = OP_MULHU;  d_a[1]  = 32'hFFFF_FFFF;  d_b[1]  = 32'hFFFF_FFFF;
        d_op[2]  = OP_MULH;   d_a[2]  = 32'hFFFF_FFFF;  d_b[2]  = 32'hFFFF_FFFF;
        d_op[3]  = OP_MULHSU; d_a[3]  = 32'hFFFF_FFFF;  d_b[3]  = 32'd2;
        d_op[4]  = OP_DIV;    d_a[4]  = 32'hFFFF_FFF9;  d_b[4]  = 32'd2;
        d_op[5]  = OP_REM;    d_a[5]  = 32'hFFFF_FFF9;  d_b[5]  = 32'd2;
        d_op[6]  = OP_DIVU;   d_a[6]  = 32'd100;        d_b[6]  = 32'd7;
        d_op[7]  = OP_REMU;   d_a[7]  = 32'd100;        d_b[7]  = 32'd7;
        d_op[8]  = OP_DIVU;   d_a[8]  = 32'd5;          d_b[8]  = 32'd0;
        d_op[9]  = OP_REMU;   d_a[9]  = 32'd5;          d_b[9]  = 32'd0;
        d_op[10] = OP_DIV;    d_a[10] = 32'h8000_0000;  d_b[10] = 32'hFFFF_FFFF;
        d_op[11] = OP_REM;    d_a[11] = 32'h8000_0000;  d_b[11] = 32'hFFFF_FFFF;

        rst   = 1'b1;
        start = 1'b0;
        op_i  = 3'b000;
        a_i   = 32'd0;
        b_i   = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_stall", stall, 1'b0);
        chk("reset_result", result, 32'd0);

        // Directed RV32M cases including divide-by-zero and signed overflow
        for (int i = 0; i < 12; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 1'b0);
        end

        // Reset in cycle 10 of a DIV: op abandoned, no done pulse
        @(negedge clk);
        start = 1'b1;
        op_i  = OP_DIV;
        a_i   = 32'd1000;
        b_i   = 32'd3;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk1("midreset_busy", busy, 1'b0);
        chk1("midreset_stall", stall, 1'b0);
        chk1("midreset_done", done, 1'b0);
        chk("midreset_result", result, 32'd0);
        repeat (40) @(negedge clk);
        run_op(OP_MUL, 32'd3, 32'd4, 1'b0);

        // Operands changed mid-CALC, then a back-to-back issue
        run_op(OP_DIVU, 32'd1234567, 32'd89, 1'b1);
        run_op(OP_MULHSU, 32'h8000_0001, 32'hFFFF_0000, 1'b0);

        // Random ops with corner-biased operands
        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("pending_at_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion required finish");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RV32M extension, in the execute stage beside the ALU. It takes the same register-file operands as the ALU, and its result is muxed with the ALU output into the writeback path. It stalls the single-cycle datapath (PC and instruction hold) while it computes. The unit handles every op in a fixed number of cycles.

## Interface
- N, 32, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  M-extension instruction decoded this cycle (held high by the stalled datapath)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  N  rs1 operand
- b  in  N  rs2 operand
- stall  out  1  hold PC/instruction; combinational
- busy  out  1  operation in progress (registered state != IDLE)
- done  out  1  one-cycle pulse; result valid, writeback this edge
- result  out  N  registered result, held until the next accepted start

One clock; reset is synchronous and active-high. The ports are clk and rst.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:** start=1 is accepted at the clock edge.
  - Latch op, sign flags and operand magnitudes.
  - Clear the accumulator and load the counter with N.
  - Go to CALC.
- **CALC:** one iteration per cycle for N cycles. The counter decrements, and the state goes to FIX when the counter reaches 0.
  - Multiply: shift-add on unsigned magnitudes, producing a 2N-bit product.
  - Divide: restoring, one quotient bit per cycle, producing an N-bit quotient and remainder.
- **FIX:** apply signs, apply special cases, register result, then go to DONE.
  - MUL uses the low N bits. MULH, MULHSU and MULHU use the high N bits.
  - The product is negated when the operand signs differ. MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - Quotient sign is sa^sb. Remainder sign is sa.
  - Divide by zero: quotient is all ones and remainder is a.
  - Signed overflow (a = 2^(N-1) negative, b = -1): quotient is a and remainder is 0.
- **DONE:** done=1 and stall=0, so the datapath writes back result and advances. start is ignored in this state. Next state is IDLE.
- **start outside IDLE:** ignored, and the latched operands are not updated.
- **stall** = (IDLE & start) | CALC | FIX.
- **Reset:**
  - State returns to IDLE. busy=0, done=0, result=0, counter=0.
  - Reset mid-operation abandons the op with no done pulse.

## Timing
- Start is sampled in IDLE at edge 0. CALC occupies cycles 1..N, FIX is cycle N+1, and done is high in cycle N+2.
- Total latency is N+2 cycles for every op, including special cases: 34 cycles at N=32.
- stall is high from the start cycle through cycle N+1 and low in the done cycle.
- busy is high in cycles 1..N+2.
- result changes only at the FIX→DONE edge and at reset.
- Back-to-back: a start arriving in the cycle after DONE (IDLE) is accepted normally. The minimum issue interval is N+3 cycles.

## Structure
- Shared package muldiv_pkg holds:
  - op encoding constants (MUL..REMU)
  - state encoding (IDLE, CALC, FIX, DONE)
  - helper predicate is_div(op) = op[2]
- Natural sub-module: cond_neg, a parameterised conditional two's-complement negator. It is used for operand magnitude at accept and for sign fix at FIX (widths N and 2N).
- The counter is clog2(N)+1 bits. The mul and div paths share the accumulator and shift registers.

## Test plan
- MUL a=7, b=0xFFFFFFFD, reset released → done exactly 34 cycles after start, result=0xFFFFFFEB; stall high in cycles 0..33 and low in cycle 34.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. All in 34 cycles.
- rst asserted in cycle 10 of a DIV:
  - Next cycle busy=0, stall=0 and result=0, with no done pulse.
  - A new MUL 3×4 then completes with 12 after 34 cycles.
- start held high through an op with a and b changed mid-CALC → result uses the values latched at accept. A second start in the cycle after DONE is accepted, and its done follows 34 cycles later.
